i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) that answers the team's I2C master on the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches its own address, ACKs it, then streams written bytes out on a valid/ready port and supplies read bytes from a valid/ready port.
- SDA is open-drain via an output-enable; SCL is input only (no clock stretching).

Parameters:
- ADDR, 7'h10, own 7-bit bus address.
- IDLE_FILL, 8'hFF, byte transmitted when a read needs data and inValid is low.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- scl_i  input  1  bus SCL level (asynchronous).
- sda_i  input  1  bus SDA level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- outData  output  8  received write byte.
- outValid  output  1  outData valid; held until outReady.
- outReady  input  1  consumer accepts outData.
- inData  input  8  byte to return on a read.
- inValid  input  1  inData available.
- inReady  output  1  one-cycle pulse; inData taken this cycle.
- rdWr  output  1  R/W bit of the last matched address (1 = read).
- busy  output  1  addressed, between matching ACK and STOP or non-matching START.
- overflow  output  1  one-cycle pulse; received byte dropped and NACKed.

Behaviour:
- Reset (reset=0 at a clock edge): all outputs 0, state IDLE, shift register and bit counter cleared. Applies mid-transfer, so sda_oe is released on the first reset edge.
- Input path: scl_i/sda_i each pass a 2-FF synchronizer plus one history FF. Edges are detected 3 cycles after the pin changes.
- START: SDA fall while SCL high. Accepted in any state, including a repeated START. Goes to ADDR, clears the bit counter and releases sda_oe.
- STOP: SDA rise while SCL high. Accepted in any state. Goes to IDLE, releases sda_oe, clears busy.
- Bits are sampled on detected SCL rise. sda_oe changes only on the cycle after a detected SCL fall.
- ADDR: shift 8 bits MSB first.
  - After the 8th rise, if bits[7:1]==ADDR: latch rdWr=bit0, set busy, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP.
- ADDR_ACK: sda_oe=1 from the next SCL fall until the following SCL fall. Then go to RX_BYTE if rdWr=0, or TX_BYTE if rdWr=1.
- RX_BYTE: after 8 rises the byte is complete.
  - If outValid=0, or outValid=1 with outReady=1 this cycle: load outData, set outValid, go to RX_ACK with ACK.
  - Otherwise: drop the byte, pulse overflow, go to RX_ACK with NACK.
- RX_ACK: for the ACK bit time, sda_oe=1 on ACK and 0 on NACK. Then go back to RX_BYTE, regardless of ACK or NACK.
- outValid clears on the cycle after outValid and outReady are both high. outData stays stable while outValid=1.
- TX_BYTE, byte load at the SCL fall that starts the byte:
  - If inValid=1: load inData and pulse inReady for 1 cycle.
  - Otherwise: load IDLE_FILL; no inReady pulse.
- TX_BYTE, bit output: drive one bit per SCL fall, MSB first, sda_oe = ~bit. After the 8th bit's SCL fall, release sda_oe and go to TX_ACK.
- TX_ACK: sample SDA on the SCL rise.
  - 0 (master ACK): go to TX_BYTE.
  - 1 (master NACK): go to WAIT_STOP.
- WAIT_STOP: sda_oe=0, ignores data until START or STOP.
- Simultaneous events:
  - A START or STOP edge beats a data-bit event in the same cycle.
  - A STOP during RX_BYTE discards the partial byte; outValid is unaffected.
- Bit counter is 3 bits wide. It wraps 7→0 at the byte boundary and is reset by START.

Test Plan:
1. Master writes addr 0x10, W, data 0x4A; outReady=1 → ACK on addr and data, outData=0x4A, outValid pulse, rdWr=0, busy until STOP.
2. Master addresses 0x11, W → sda_oe stays 0 for the whole frame, no outValid, busy=0.
3. Master reads 2 bytes from 0x10; inData/inValid present 0xA5 then 0x3C; master ACKs byte 1, NACKs byte 2 → SDA carries 1010_0101 then 0011_1100, two inReady pulses, sda_oe=0 after the NACK.
4. Read from 0x10 with inValid=0 → byte 0xFF on SDA, no inReady pulse.
5. Write of 0x01, 0x02 with outReady=0 → 0x01 ACKed and held in outData, 0x02 NACKed with an overflow pulse, outData stays 0x01.
6. Hold reset=0 for 2 clocks during the ACK bit of a write → sda_oe=0 at the first reset edge, all outputs 0. The next START plus addr 0x10 is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// 7-bit address I2C target: oversampled SCL/SDA, START/STOP detection,
// write bytes streamed out and read bytes pulled in over valid/ready ports.
module i2c_target #(
    parameter logic [6:0] ADDR      = 7'h10,
    parameter logic [7:0] IDLE_FILL = 8'hFF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    input  logic [7:0] inData,
    input  logic       inValid,
    output logic       inReady,
    output logic       rdWr,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [2:0] {
        stIdle, stAddr, stAddrAck, stRxByte, stRxAck, stTxByte, stTxAck, stWaitStop
    } state_t;

    state_t     state;
    logic       sclMeta, sclSync, sclPrev;
    logic       sdaMeta, sdaSync, sdaPrev;
    logic [7:0] shiftReg;
    logic [2:0] bitCnt;
    logic       ackPhase;   // second SCL fall of an ACK slot ends the slot
    logic       ackGood;
    logic       masterAck;

    logic       sclRise, sclFall, startDet, stopDet;
    logic [7:0] rxByte, txByte;

    assign sclRise  = sclSync & ~sclPrev;
    assign sclFall  = ~sclSync & sclPrev;
    assign startDet = sclSync & sclPrev & sdaPrev & ~sdaSync;
    assign stopDet  = sclSync & sclPrev & ~sdaPrev & sdaSync;
    assign rxByte   = {shiftReg[6:0], sdaSync};
    assign txByte   = inValid ? inData : IDLE_FILL;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= stIdle;
            sclMeta   <= 1'b1;
            sclSync   <= 1'b1;
            sclPrev   <= 1'b1;
            sdaMeta   <= 1'b1;
            sdaSync   <= 1'b1;
            sdaPrev   <= 1'b1;
            shiftReg  <= 8'h00;
            bitCnt    <= 3'd0;
            ackPhase  <= 1'b0;
            ackGood   <= 1'b0;
            masterAck <= 1'b0;
            sda_oe    <= 1'b0;
            outData   <= 8'h00;
            outValid  <= 1'b0;
            inReady   <= 1'b0;
            rdWr      <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sclMeta  <= scl_i;
            sclSync  <= sclMeta;
            sclPrev  <= sclSync;
            sdaMeta  <= sda_i;
            sdaSync  <= sdaMeta;
            sdaPrev  <= sdaSync;
            inReady  <= 1'b0;
            overflow <= 1'b0;
            if (outValid && outReady)
                outValid <= 1'b0;

            // Bus conditions take priority over any bit event in the same cycle
            if (startDet) begin
                state     <= stAddr;
                bitCnt    <= 3'd0;
                sda_oe    <= 1'b0;
                ackPhase  <= 1'b0;
                masterAck <= 1'b0;
            end else if (stopDet) begin
                state     <= stIdle;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ackPhase  <= 1'b0;
                masterAck <= 1'b0;
            end else begin
                case (state)
                    stAddr: if (sclRise) begin
                        shiftReg <= rxByte;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (rxByte[7:1] == ADDR) begin
                                rdWr  <= rxByte[0];
                                busy  <= 1'b1;
                                state <= stAddrAck;
                            end else begin
                                busy  <= 1'b0;
                                state <= stWaitStop;
                            end
                        end
                    end
                    stAddrAck: if (sclFall) begin
                        if (!ackPhase) begin
                            sda_oe   <= 1'b1;
                            ackPhase <= 1'b1;
                        end else begin
                            ackPhase <= 1'b0;
                            bitCnt   <= 3'd0;
                            if (rdWr) begin
                                shiftReg <= {txByte[6:0], 1'b0};
                                sda_oe   <= ~txByte[7];
                                inReady  <= inValid;
                                state    <= stTxByte;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= stRxByte;
                            end
                        end
                    end
                    stRxByte: if (sclRise) begin
                        shiftReg <= rxByte;
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (!outValid || outReady) begin
                                outData  <= rxByte;
                                outValid <= 1'b1;
                                ackGood  <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                                ackGood  <= 1'b0;
                            end
                            state <= stRxAck;
                        end
                    end
                    stRxAck: if (sclFall) begin
                        if (!ackPhase) begin
                            sda_oe   <= ackGood;
                            ackPhase <= 1'b1;
                        end else begin
                            sda_oe   <= 1'b0;
                            ackPhase <= 1'b0;
                            state    <= stRxByte;
                        end
                    end
                    stTxByte: if (sclFall) begin
                        if (bitCnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            bitCnt <= 3'd0;
                            state  <= stTxAck;
                        end else begin
                            sda_oe   <= ~shiftReg[7];
                            shiftReg <= {shiftReg[6:0], 1'b0};
                            bitCnt   <= bitCnt + 3'd1;
                        end
                    end
                    stTxAck: begin
                        if (sclRise) begin
                            if (sdaSync)
                                state <= stWaitStop;
                            else
                                masterAck <= 1'b1;
                        end else if (sclFall && masterAck) begin
                            masterAck <= 1'b0;
                            shiftReg  <= {txByte[6:0], 1'b0};
                            sda_oe    <= ~txByte[7];
                            inReady   <= inValid;
                            state     <= stTxByte;
                        end
                    end
                    stWaitStop: sda_oe <= 1'b0;
                    default:    sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged master drives random and directed
// frames; a monitor process checks the valid/ready ports against queued expectations.
module tb_i2c_target;
    localparam int Q = 8;   // clocks per quarter SCL period

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sclM = 1'b1, sdaM = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady = 1'b1;
    logic [7:0] inData = 8'h00;
    logic       inValid = 1'b0;
    logic       inReady, rdWr, busy, overflow;

    always #5 clock = ~clock;

    assign scl_i = sclM;
    assign sda_i = sdaM & ~sda_oe;

    i2c_target dut (
        .clock(clock), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .inData(inData), .inValid(inValid), .inReady(inReady),
        .rdWr(rdWr), .busy(busy), .overflow(overflow)
    );

    int compared = 0, mismatched = 0;
    logic [7:0] expOut[$];
    logic [7:0] expIn[$];
    int ovfCount = 0, inRdyCount = 0, oeHighCount = 0;
    int expOvf = 0, expInRdy = 0;
    bit modelOcc = 0;
    logic [7:0] txData[4];
    logic       txValid[4];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations when the DUT presents a handshake
    always @(negedge clock) begin
        if (reset) begin
            if (outValid && outReady) begin
                check("outQueueNonEmpty", 32'(expOut.size() > 0), 1);
                if (expOut.size() > 0) check("outData", outData, expOut.pop_front());
            end
            if (inReady) begin
                inRdyCount++;
                check("inQueueNonEmpty", 32'(expIn.size() > 0), 1);
                if (expIn.size() > 0) check("inReadyData", inData, expIn.pop_front());
            end
            if (overflow) ovfCount++;
            if (sda_oe) oeHighCount++;
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic startCond();
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic stopCond();
        sdaM = 1'b0; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        sdaM = 1'b1; waitClk(Q);
    endtask

    task automatic writeBit(input logic b);
        sdaM = b;    waitClk(Q);
        sclM = 1'b1; waitClk(2 * Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic readBit(output logic b);
        sdaM = 1'b1; waitClk(Q);
        sclM = 1'b1; waitClk(Q);
        b = sda_i;   waitClk(Q);
        sclM = 1'b0; waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) writeBit(v[i]);
    endtask

    task automatic readByte(output logic [7:0] v);
        logic b;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            readBit(b);
            v = {v[6:0], b};
        end
    endtask

    task automatic setOutReady(input logic r);
        @(posedge clock); #1 outReady = r;
    endtask

    // One complete frame; expectations come from the bus rules, not the DUT
    task automatic transfer(input logic [6:0] a, input logic rw, input int len);
        logic       match, ack, accept;
        logic [7:0] got, exp;
        match = (a == 7'h10);
        oeHighCount = 0;
        $display("txn addr=%02h rw=%0d len=%0d outReady=%0d d0=%02h v0=%0d",
                 a, rw, len, outReady, txData[0], txValid[0]);
        startCond();
        writeByte({a, rw});
        if (rw && match) begin
            inData = txData[0]; inValid = txValid[0];
            if (txValid[0]) begin expIn.push_back(txData[0]); expInRdy++; end
        end
        readBit(ack);
        check("addrAck", ack, !match);
        if (!match) begin
            if (!rw) begin
                for (int i = 0; i < len; i++) begin
                    writeByte(txData[i]);
                    readBit(ack);
                    check("nackData", ack, 1);
                end
            end
        end else begin
            check("rdWr", rdWr, rw);
            check("busyAddressed", busy, 1);
            if (!rw) begin
                for (int i = 0; i < len; i++) begin
                    accept = !modelOcc || outReady;
                    if (accept) begin
                        expOut.push_back(txData[i]);
                        modelOcc = !outReady;
                    end else expOvf++;
                    writeByte(txData[i]);
                    readBit(ack);
                    check("dataAck", ack, !accept);
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    exp = txValid[i] ? txData[i] : 8'hFF;
                    readByte(got);
                    check("readByte", got, exp);
                    if (i < len - 1) begin
                        inData = txData[i+1]; inValid = txValid[i+1];
                        if (txValid[i+1]) begin expIn.push_back(txData[i+1]); expInRdy++; end
                        writeBit(1'b0);
                    end else begin
                        writeBit(1'b1);
                        check("oeAfterNack", sda_oe, 0);
                    end
                end
            end
        end
        stopCond();
        inValid = 1'b0;
        waitClk(4);
        check("busyAfterStop", busy, 0);
        check("overflowCount", ovfCount, expOvf);
        check("inReadyCount", inRdyCount, expInRdy);
        if (!match) check("silentFrame", oeHighCount, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        logic       rw;
        int         len;

        waitClk(3);
        check("resetOutputs", {sda_oe, outData, outValid, inReady, rdWr, busy, overflow}, 0);
        reset = 1'b1;
        waitClk(4);

        // Write 0x4A, consumer ready
        txData[0] = 8'h4A;
        transfer(7'h10, 1'b0, 1);
        // Foreign address
        txData[0] = 8'h55;
        transfer(7'h11, 1'b0, 1);
        // Two-byte read, ACK then NACK
        txData[0] = 8'hA5; txValid[0] = 1'b1;
        txData[1] = 8'h3C; txValid[1] = 1'b1;
        transfer(7'h10, 1'b1, 2);
        // Read with nothing available
        txValid[0] = 1'b0;
        transfer(7'h10, 1'b1, 1);
        // Consumer stalled: second byte overflows
        setOutReady(1'b0);
        txData[0] = 8'h01; txData[1] = 8'h02;
        transfer(7'h10, 1'b0, 2);
        check("heldValid", outValid, 1);
        check("heldData", outData, 8'h01);
        setOutReady(1'b1);
        waitClk(3);
        modelOcc = 0;
        check("drained", expOut.size(), 0);

        // Reset asserted while the target drives the address ACK
        startCond();
        writeByte({7'h10, 1'b0});
        check("ackDriveBeforeReset", sda_oe, 1);
        reset = 1'b0;
        waitClk(1);
        check("resetMidFrame", {sda_oe, outData, outValid, inReady, rdWr, busy, overflow}, 0);
        waitClk(1);
        reset = 1'b1;
        sdaM = 1'b1;
        waitClk(4);
        txData[0] = 8'hC3;
        transfer(7'h10, 1'b0, 1);

        // Randomized frames
        for (int t = 0; t < 14; t++) begin
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h10;
            rw  = 1'($urandom);
            len = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                txData[i]  = 8'($urandom);
                txValid[i] = ($urandom_range(0, 3) != 0);
            end
            transfer(a, rw, len);
        end

        waitClk(4);
        check("outQueueEmpty", expOut.size(), 0);
        check("inQueueEmpty", expIn.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
